// File: rtl/imem_boot_loader.sv
// Loads a byte-streamed, XOR-checksummed program into instruction memory, then releases the CPU.
// Latency: one write cycle after each 4th data byte; byte_ready drops during that write cycle.
// Backpressure: bytes move only on byte_valid & byte_ready; start aborts and discards a same-cycle byte.
module imem_boot_loader #(
    parameter int DEPTH = 1024,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    input  logic [31:0]      pc,
    output logic [31:0]      imem_addr,
    output logic             imem_we,
    output logic [31:0]      imem_wdata,
    output logic             cpu_run,
    output logic             busy,
    output logic             load_done,
    output logic             load_err,
    output logic [CNT_W-1:0] words_loaded
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, CHK, RUN, ERROR} state_t;

    state_t           state;
    logic [7:0]       hdr_hi;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] idx;
    logic [1:0]       bcnt;
    logic [7:0]       csum;
    logic [23:0]      asm_q;
    logic [31:0]      waddr;
    logic [15:0]      count_n;
    logic             xfer;

    assign busy       = (state == HDR_HI) || (state == HDR_LO) || (state == DATA) || (state == CHK);
    assign byte_ready = busy && !imem_we;
    // start wins over a handshake in the same cycle, so that byte is dropped
    assign xfer       = byte_valid && byte_ready && !start;
    assign cpu_run    = (state == RUN);
    assign imem_addr  = cpu_run ? pc : waddr;
    assign count_n    = {hdr_hi, byte_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            hdr_hi       <= '0;
            count        <= '0;
            idx          <= '0;
            bcnt         <= '0;
            csum         <= '0;
            asm_q        <= '0;
            waddr        <= '0;
            imem_we      <= 1'b0;
            imem_wdata   <= '0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
        end else begin
            imem_we <= 1'b0;
            if (start) begin
                state        <= HDR_HI;
                idx          <= '0;
                bcnt         <= '0;
                csum         <= '0;
                load_done    <= 1'b0;
                load_err     <= 1'b0;
                words_loaded <= '0;
            end else begin
                case (state)
                    HDR_HI: if (xfer) begin
                        hdr_hi <= byte_data;
                        csum   <= csum ^ byte_data;
                        state  <= HDR_LO;
                    end
                    HDR_LO: if (xfer) begin
                        csum  <= csum ^ byte_data;
                        count <= CNT_W'(count_n);
                        if (32'(count_n) > DEPTH) begin
                            state    <= ERROR;
                            load_err <= 1'b1;
                        end else if (count_n == 16'd0) begin
                            state <= CHK;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        if (imem_we) begin
                            // idx wraps only after the final word of a DEPTH-sized load
                            idx          <= idx + IDX_W'(1);
                            words_loaded <= words_loaded + CNT_W'(1);
                            if (words_loaded + CNT_W'(1) == count)
                                state <= CHK;
                        end else if (xfer) begin
                            csum <= csum ^ byte_data;
                            bcnt <= bcnt + 2'd1;
                            if (bcnt == 2'd3) begin
                                imem_we    <= 1'b1;
                                imem_wdata <= {asm_q, byte_data};
                                waddr      <= 32'({idx, 2'b00});
                            end else begin
                                asm_q <= {asm_q[15:0], byte_data};
                            end
                        end
                    end
                    CHK: if (xfer) begin
                        if (byte_data == csum) begin
                            state     <= RUN;
                            load_done <= 1'b1;
                        end else begin
                            state    <= ERROR;
                            load_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
